// File: rtl/counter_pkg.sv
// Shared constants for the parametrised up/down counter family:
// direction and boundary-mode encodings plus default sizing.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int DEF_DATA_SIZE    = 4;
  localparam int DEF_PRESCALE_DIV = 4;

endpackage

// File: rtl/counter_prescaler.sv
// Enable divider: counts en-qualified cycles 0..PRESCALE_DIV-1 and
// raises tick on the last one, so the main counter steps once per PRESCALE_DIV enables.
module counter_prescaler #(
  parameter int PRESCALE_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE_DIV - 1);

  logic [CW-1:0] div_cnt;

  assign tick = en && (div_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with load, wrap/saturate, tc pulse and sticky ovf.
// Optional enable prescaler is built when COUNTER_PRESCALER_EN is defined.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int DATA_SIZE    = DEF_DATA_SIZE,
  parameter int MAX_COUNT    = 2**DATA_SIZE - 1,
  parameter int PRESCALE_DIV = DEF_PRESCALE_DIV
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 up_dn,
  input  logic                 load,
  input  logic [DATA_SIZE-1:0] load_val,
  input  logic                 sat_mode,
  input  logic                 clr_ovf,
  output logic [DATA_SIZE-1:0] q_out,
  output logic                 tc,
  output logic                 ovf
);

  localparam logic [DATA_SIZE-1:0] MAX_Q = DATA_SIZE'(MAX_COUNT);

  if (DATA_SIZE < 2 || MAX_COUNT < 1 || PRESCALE_DIV < 2) begin : g_param_check
    $error("param_updown_counter: illegal parameter combination");
  end

  // Returns {boundary_event, next_count}; all arithmetic stays within DATA_SIZE bits.
  function automatic logic [DATA_SIZE:0] step_count(
    input logic [DATA_SIZE-1:0] q,
    input logic                 dir,
    input logic                 mode
  );
    logic [DATA_SIZE-1:0] nxt;
    logic                 bound;
    bound = 1'b0;
    if (dir == DIR_UP) begin
      if (q == MAX_Q) begin
        bound = 1'b1;
        nxt   = (mode == MODE_SAT) ? MAX_Q : '0;
      end else begin
        nxt = q + 1'b1;
      end
    end else begin
      if (q == '0) begin
        bound = 1'b1;
        nxt   = (mode == MODE_SAT) ? '0 : MAX_Q;
      end else begin
        nxt = q - 1'b1;
      end
    end
    return {bound, nxt};
  endfunction

  function automatic logic [DATA_SIZE-1:0] clamp_load(input logic [DATA_SIZE-1:0] v);
    return (v > MAX_Q) ? MAX_Q : v;
  endfunction

  logic                 step_tick;
  logic [DATA_SIZE:0]   step_res;
  logic                 do_step;
  logic                 bound_evt;

`ifdef COUNTER_PRESCALER_EN
  counter_prescaler #(
    .PRESCALE_DIV (PRESCALE_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (load),
    .tick  (step_tick)
  );
`else
  assign step_tick = 1'b1;
`endif

  assign step_res  = step_count(q_out, up_dn, sat_mode);
  assign do_step   = !load && en && step_tick;
  assign bound_evt = do_step && step_res[DATA_SIZE];

  always_ff @(posedge clk) begin
    if (reset) begin
      q_out <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      tc <= bound_evt;
      if (load) begin
        q_out <= clamp_load(load_val);
      end else if (do_step) begin
        q_out <= step_res[DATA_SIZE-1:0];
      end
      // A boundary event on the same edge as clr_ovf keeps the flag set.
      if (bound_evt) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter (DATA_SIZE=4, MAX_COUNT=9, PRESCALE_DIV=4).
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       reset, en, up_dn, load, sat_mode, clr_ovf;
  logic [3:0] load_val;
  logic [3:0] q_out;
  logic       tc, ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  param_updown_counter #(
    .DATA_SIZE    (4),
    .MAX_COUNT    (9),
    .PRESCALE_DIV (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .sat_mode (sat_mode),
    .clr_ovf  (clr_ovf),
    .q_out    (q_out),
    .tc       (tc),
    .ovf      (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0;
    load_val = '0; sat_mode = 1'b0; clr_ovf = 1'b0;
    tick();
    check("rst_q", q_out, 0);
    check("rst_tc", tc, 0);
    check("rst_ovf", ovf, 0);
    reset = 1'b0;

`ifdef COUNTER_PRESCALER_EN
    en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("pre_q%0d", i), q_out, i / 4);
    end
    tick(); tick();
    check("pre_mid_q", q_out, 3);
    do_reset();
    check("pre_rst_q", q_out, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("pre_after_rst%0d", i), q_out, (i == 4) ? 1 : 0);
    end
    tick(); tick();
    load = 1'b1; load_val = 4'd2;
    tick();
    load = 1'b0;
    check("pre_load_q", q_out, 2);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("pre_after_load%0d", i), q_out, (i == 4) ? 3 : 2);
    end
`else
    // wrap up-count through MAX_COUNT
    en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("wrap_q%0d", i), q_out, i % 10);
      check($sformatf("wrap_tc%0d", i), tc, (i == 10) ? 1 : 0);
    end
    check("wrap_ovf", ovf, 1);

    // saturating up-count
    do_reset();
    check("rst2_ovf", ovf, 0);
    sat_mode = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("sat_q%0d", i), q_out, (i > 9) ? 9 : i);
      check($sformatf("sat_tc%0d", i), tc, (i >= 10) ? 1 : 0);
    end
    check("sat_ovf", ovf, 1);

    // down from zero, wrap then saturate
    do_reset();
    up_dn = 1'b0; sat_mode = 1'b0;
    tick();
    check("dn_wrap_q", q_out, 9);
    check("dn_wrap_tc", tc, 1);
    tick();
    check("dn_q8", q_out, 8);
    check("dn_tc8", tc, 0);
    do_reset();
    sat_mode = 1'b1;
    tick();
    check("dn_sat_q", q_out, 0);
    check("dn_sat_tc", tc, 1);
    tick();
    check("dn_sat_q2", q_out, 0);
    check("dn_sat_tc2", tc, 1);

    // load beats step, clamps to MAX_COUNT, keeps ovf
    up_dn = 1'b1; sat_mode = 1'b0;
    load = 1'b1; load_val = 4'd15;
    tick();
    check("load15_q", q_out, 9);
    check("load15_tc", tc, 0);
    check("load_ovf_kept", ovf, 1);
    load_val = 4'd5;
    tick();
    check("load5_q", q_out, 5);
    load = 1'b0; en = 1'b0;
    tick();
    check("hold_q", q_out, 5);
    check("hold_tc", tc, 0);

    // ovf set wins over clr_ovf, then clears alone
    load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0; en = 1'b1; clr_ovf = 1'b1;
    tick();
    check("clr_wrap_q", q_out, 0);
    check("clr_wrap_tc", tc, 1);
    check("clr_wrap_ovf", ovf, 1);
    en = 1'b0;
    tick();
    check("clr_ovf", ovf, 0);
    check("clr_tc", tc, 0);
    clr_ovf = 1'b0;
    en = 1'b1;
    tick();
    check("resume_q", q_out, 1);
    check("resume_ovf", ovf, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
